sentiment_color_fsm: RTL

Parametrised, sequential successor to the single-threshold sentiment colour stage: classifies a float32 class-difference score against NUM_LEVELS-1 programmable thresholds, debounces level changes across video frames with a hysteresis state machine, and fades the on-screen colour toward a programmable palette entry. It sits between the classifier's score output and the VGA controller, driving the per-pixel RGB with blank gating.

---
 rtl/sentiment_color_if.sv | 38 +++
 rtl/sentiment_color_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sentiment_color_if.sv
// Score, programming and pixel-colour signals of the sentiment colour stage.
// The DUT side is the slave modport; the driving side uses master.
interface sentiment_color_if #(
  parameter int NUM_LEVELS = 3,
  parameter int COLOR_W    = 8
);
  localparam int LW = $clog2(NUM_LEVELS);

  logic                   frame_start;
  logic                   score_valid;
  logic [31:0]            score;
  logic                   thr_wr;
  logic [LW-1:0]          thr_idx;
  logic [31:0]            thr_val;
  logic                   pal_wr;
  logic [LW-1:0]          pal_idx;
  logic [3*COLOR_W-1:0]   pal_rgb;
  logic                   blank;
  logic [COLOR_W-1:0]     Red;
  logic [COLOR_W-1:0]     Green;
  logic [COLOR_W-1:0]     Blue;
  logic [LW-1:0]          level;
  logic                   level_changed;

  modport master (
    output frame_start, score_valid, score,
    output thr_wr, thr_idx, thr_val,
    output pal_wr, pal_idx, pal_rgb, blank,
    input  Red, Green, Blue, level, level_changed
  );

  modport slave (
    input  frame_start, score_valid, score,
    input  thr_wr, thr_idx, thr_val,
    input  pal_wr, pal_idx, pal_rgb, blank,
    output Red, Green, Blue, level, level_changed
  );
endinterface

// File: rtl/sentiment_color_fsm.sv
// Float32 score -> debounced colour level -> per-frame colour fade.
// Level changes must persist HOLD_FRAMES frames before they are committed.
module sentiment_color_fsm #(
  parameter int NUM_LEVELS  = 3,
  parameter int COLOR_W     = 8,
  parameter int HOLD_FRAMES = 4,
  parameter int FADE_STEP   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  sentiment_color_if.slave bus
);
  localparam int LW = $clog2(NUM_LEVELS);
  localparam int TN = 2 ** LW;
  localparam int RW = 3 * COLOR_W;

  localparam logic [COLOR_W-1:0] C7F = COLOR_W'(8'h7F);
  localparam logic [COLOR_W-1:0] CZ  = '0;
  localparam logic [RW-1:0] RED = {C7F, CZ, CZ};
  localparam logic [RW-1:0] GRN = {CZ, C7F, CZ};
  localparam logic [RW-1:0] YEL = {C7F, C7F, CZ};

  localparam logic [COLOR_W:0]   STEP_W = (COLOR_W+1)'(FADE_STEP);
  localparam logic [COLOR_W-1:0] STEP_N = COLOR_W'(FADE_STEP);
  localparam logic [3:0]         HOLD4  = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {NO_DATA, STABLE, PENDING} state_t;

  logic [31:0]   thr_q [TN];
  logic [RW-1:0] pal_q [TN];

  logic [31:0]   score_q;
  logic          s1v_q;
  logic [LW-1:0] cand_q, cand_c;
  logic          cvld_q;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] target_q, target_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          lc_q, lc_d;

  logic [RW-1:0]      rgb_q, rgb_d, tgt_rgb;
  logic [COLOR_W-1:0] cur, tgt, nxt;

  // Signed IEEE a > b; NaN never greater, +0 equals -0.
  function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
    logic an, bn;
    an = (&a[30:23]) && (|a[22:0]);
    bn = (&b[30:23]) && (|b[22:0]);
    if (an || bn) return 1'b0;
    if (a[30:0] == '0 && b[30:0] == '0) return 1'b0;
    if (a[31] != b[31]) return b[31];
    return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  endfunction

  always_comb begin
    cand_c = '0;
    for (int k = 0; k < TN; k++)
      if (k < NUM_LEVELS-1 && fgt(score_q, thr_q[k]))
        cand_c = cand_c + LW'(1);
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    lc_d     = 1'b0;
    if (bus.frame_start && cvld_q) begin
      unique case (state_q)
        NO_DATA: begin
          level_d = cand_q;
          lc_d    = 1'b1;
          state_d = STABLE;
        end
        STABLE: if (cand_q != level_q) begin
          target_d = cand_q;
          cnt_d    = 4'd1;
          if (HOLD_FRAMES == 1) begin
            level_d = cand_q;
            lc_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = PENDING;
          end
        end
        PENDING: if (cand_q == target_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == HOLD4) begin
            level_d = target_q;
            lc_d    = 1'b1;
            cnt_d   = '0;
            state_d = STABLE;
          end
        end else if (cand_q == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          target_d = cand_q;
          cnt_d    = 4'd1;
        end
        default: state_d = NO_DATA;
      endcase
    end
  end

  // Fade targets the level held before this edge's commit.
  always_comb begin
    rgb_d   = rgb_q;
    tgt_rgb = pal_q[level_q];
    cur     = '0;
    tgt     = '0;
    nxt     = '0;
    if (bus.frame_start) begin
      for (int ch = 0; ch < 3; ch++) begin
        cur = rgb_q[ch*COLOR_W +: COLOR_W];
        tgt = tgt_rgb[ch*COLOR_W +: COLOR_W];
        unique case (1'b1)
          cur < tgt: nxt = ({1'b0, tgt - cur} > STEP_W) ? cur + STEP_N : tgt;
          cur > tgt: nxt = ({1'b0, cur - tgt} > STEP_W) ? cur - STEP_N : tgt;
          default:   nxt = cur;
        endcase
        rgb_d[ch*COLOR_W +: COLOR_W] = nxt;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      score_q  <= '0;
      s1v_q    <= 1'b0;
      cand_q   <= '0;
      cvld_q   <= 1'b0;
      state_q  <= NO_DATA;
      level_q  <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      lc_q     <= 1'b0;
      rgb_q    <= '0;
      for (int k = 0; k < TN; k++) begin
        thr_q[k] <= (k == 0) ? 32'h3E80_0000 : 32'h3FA0_0000;
        pal_q[k] <= (k == 0) ? RED : (k == NUM_LEVELS-1) ? GRN : YEL;
      end
    end else begin
      s1v_q <= bus.score_valid;
      if (bus.score_valid) score_q <= bus.score;
      if (s1v_q) begin
        cand_q <= cand_c;
        cvld_q <= 1'b1;
      end
      if (bus.thr_wr && int'(bus.thr_idx) < NUM_LEVELS-1)
        thr_q[bus.thr_idx] <= bus.thr_val;
      if (bus.pal_wr && int'(bus.pal_idx) < NUM_LEVELS)
        pal_q[bus.pal_idx] <= bus.pal_rgb;
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      lc_q     <= lc_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.Red           = bus.blank ? '0 : rgb_q[2*COLOR_W +: COLOR_W];
  assign bus.Green         = bus.blank ? '0 : rgb_q[COLOR_W +: COLOR_W];
  assign bus.Blue          = bus.blank ? '0 : rgb_q[0 +: COLOR_W];
  assign bus.level         = level_q;
  assign bus.level_changed = lc_q;
endmodule
